// File: rtl/register_file.sv
// RV32I integer register file: two registered read ports with write-to-read
// bypass, one synchronous write port, x0 hardwired to zero, x2 reset to SP_INIT.
module register_file #(
  parameter int                DWIDTH  = 32,
  parameter int                NREGS   = 32,
  parameter logic [DWIDTH-1:0] SP_INIT = 32'h0110_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic              rden_i,
  input  logic [4:0]        rd_i,
  input  logic [DWIDTH-1:0] datawb_i,
  input  logic              regwren_i,
  output logic [DWIDTH-1:0] rs1data_o,
  output logic [DWIDTH-1:0] rs2data_o
);

  localparam int         IW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [5:0] NREGS_L = 6'(NREGS);

  logic [DWIDTH-1:0] regs_q [NREGS];
  logic [DWIDTH-1:0] regs_d [NREGS];
  logic [DWIDTH-1:0] rs1data_q, rs1data_d;
  logic [DWIDTH-1:0] rs2data_q, rs2data_d;
  logic              wr_valid;

  function automatic logic addr_in_range(input logic [4:0] a);
    return ({1'b0, a} < NREGS_L);
  endfunction

  // A write to x0 or to a non-existent register is dropped, and never bypasses.
  assign wr_valid = regwren_i && (rd_i != 5'd0) && addr_in_range(rd_i);

  function automatic logic [DWIDTH-1:0] read_value(input logic [4:0] a);
    if (a == 5'd0 || !addr_in_range(a)) return '0;
    else if (wr_valid && rd_i == a)     return datawb_i;
    else                                return regs_q[a[IW-1:0]];
  endfunction

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    regs_d    = regs_q;
    rs1data_d = rs1data_q;
    rs2data_d = rs2data_q;
    if (wr_valid) regs_d[rd_i[IW-1:0]] = datawb_i;
    if (rden_i) begin
      rs1data_d = read_value(rs1_i);
      rs2data_d = read_value(rs2_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the architectural registers have defined reset contents (x2 is
      // the stack pointer), so this array is built from resettable flops
      // rather than an inferred RAM macro.
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == 2) ? SP_INIT : '0;
      end
      rs1data_q <= '0;
      rs2data_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      regs_q    <= regs_d;
      rs1data_q <= rs1data_d;
      rs2data_q <= rs2data_d;
    end
  end

  assign rs1data_o = rs1data_q;
  assign rs2data_o = rs2data_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by
// random traffic compared against an array-based architectural model.
module tb_register_file;

  localparam logic [31:0] SP_INIT = 32'h0110_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_i, rs2_i, rd_i;
  logic        rden_i, regwren_i;
  logic [31:0] datawb_i;
  logic [31:0] rs1data_o, rs2data_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_regs [32];
  logic [31:0] exp_rs1, exp_rs2;

  register_file #(.DWIDTH(32), .NREGS(32), .SP_INIT(SP_INIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .rden_i    (rden_i),
    .rd_i      (rd_i),
    .datawb_i  (datawb_i),
    .regwren_i (regwren_i),
    .rs1data_o (rs1data_o),
    .rs2data_o (rs2data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (model_regs[i]) model_regs[i] = '0;
    model_regs[2] = SP_INIT;
    exp_rs1 = '0;
    exp_rs2 = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] rd, input logic [31:0] d);
    if (a == 0)             return '0;
    if (we && rd == a)      return d;
    return model_regs[a];
  endfunction

  // One clock cycle: drive inputs, predict, clock, then check both read ports.
  task automatic step(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                      input logic rden, input logic we, input logic [4:0] rd,
                      input logic [31:0] d);
    rs1_i = r1; rs2_i = r2; rden_i = rden; regwren_i = we; rd_i = rd; datawb_i = d;
    if (rden) begin
      exp_rs1 = model_read(r1, we, rd, d);
      exp_rs2 = model_read(r2, we, rd, d);
    end
    if (we && rd != 0) model_regs[rd] = d;
    @(posedge clk);
    #1;
    check({tag, "_rs1"}, rs1data_o, exp_rs1);
    check({tag, "_rs2"}, rs2data_o, exp_rs2);
  endtask

  initial begin
    // Reset held low with a pending write and read: both must be ignored.
    rst = 1'b0;
    rs1_i = 5'd2; rs2_i = 5'd5; rden_i = 1'b1;
    regwren_i = 1'b1; rd_i = 5'd5; datawb_i = 32'hAAAA_AAAA;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rs1", rs1data_o, 32'h0);
    check("reset_rs2", rs2data_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    step("after_reset", 5'd2, 5'd5, 1'b1, 1'b0, 5'd0, 32'h0);
    check("after_reset_sp", rs1data_o, SP_INIT);

    step("write_x5",  5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    step("read_x5",   5'd5, 5'd5, 1'b1, 1'b0, 5'd0, 32'h0);
    check("read_x5_val", rs1data_o, 32'hDEAD_BEEF);

    step("x0_same",   5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step("x0_next",   5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);

    step("set_x7",    5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 32'h1);
    step("set_x6",    5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 32'h66);
    step("bypass",    5'd7, 5'd6, 1'b1, 1'b1, 5'd7, 32'h1234);
    check("bypass_val", rs1data_o, 32'h1234);

    step("stall0",    5'd3, 5'd4, 1'b0, 1'b1, 5'd3, 32'd9);
    step("stall1",    5'd1, 5'd3, 1'b0, 1'b1, 5'd3, 32'd9);
    step("stall2",    5'd3, 5'd3, 1'b0, 1'b1, 5'd3, 32'd9);
    check("stall_hold", rs1data_o, 32'h1234);
    step("unstall",   5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);
    check("unstall_x3", rs1data_o, 32'd9);

    step("dual_bypass", 5'd10, 5'd10, 1'b1, 1'b1, 5'd10, 32'h0ABC);

    step("set_x9",    5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 32'd4);
    step("read_x9",   5'd9, 5'd2, 1'b1, 1'b0, 5'd0, 32'h0);
    // Asynchronous reset between clock edges, checked before any edge.
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("async_rs1", rs1data_o, 32'h0);
    check("async_rs2", rs2data_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step("post_async", 5'd9, 5'd2, 1'b1, 1'b0, 5'd0, 32'h0);

    // Random traffic; a narrow address range makes bypass and x0 hits common.
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  r1, r2, rd;
      logic        we, rden;
      logic [31:0] d;
      r1   = 5'($urandom_range(0, 7));
      r2   = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      rd   = ($urandom_range(0, 2) == 0) ? r1 : 5'($urandom_range(0, 7));
      we   = 1'($urandom_range(0, 1));
      rden = ($urandom_range(0, 4) != 0);
      d    = $urandom;
      step("rand", r1, r2, rden, we, rd, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
